sap1_out_display: RTL and testbench

Output-port display stage fed by the SAP-1 processor's output register. Captures the 8-bit value the processor loads into its output register on the LO strobe. Converts it to three BCD digits with a sequential double-dabble engine, then time-multiplexes the digits onto a common 7-segment bus with leading-zero blanking. Sits directly downstream of the CPU's OUT register and is the last stage before the board pins.

---
 rtl/sap1_out_display.sv | 168 ++++++++++++++++
 tb/tb_sap1_out_display.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sap1_out_display.sv
// SAP-1 output display: captures the OUT register byte, converts it to BCD with a sequential
// double-dabble engine and multiplexes three digits onto a shared 7-segment bus.
module sap1_out_display #(
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  out_data,
  input  logic        lo,
  output logic        busy,
  output logic        disp_valid,
  output logic [11:0] bcd,
  output logic [2:0]  an,
  output logic [6:0]  seg
);

  typedef enum logic [1:0] {StIdle, StConv, StLatch} state_e;

  state_e      state_q, state_d;
  logic [19:0] shift_q, shift_d;
  logic [2:0]  iter_q, iter_d;
  logic        pending_q, pending_d;
  logic [7:0]  pend_data_q, pend_data_d;
  logic [11:0] bcd_q, bcd_d;
  logic        disp_valid_q, disp_valid_d;
  logic        busy_q;
  logic [15:0] refresh_q, refresh_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  digit;
  logic        blank;

  // One double-dabble iteration: correct every BCD nibble, then shift the whole register.
  function automatic logic [19:0] dabble_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    iter_d       = iter_q;
    pending_d    = pending_q;
    pend_data_d  = pend_data_q;
    bcd_d        = bcd_q;
    disp_valid_d = disp_valid_q;
    case (state_q)
      StIdle: begin
        if (lo) begin
          shift_d = {12'h000, out_data};
          iter_d  = 3'd0;
          state_d = StConv;
        end
      end
      StConv: begin
        shift_d = dabble_step(shift_q);
        iter_d  = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = StLatch;
        // Only the newest byte arriving mid-conversion is kept.
        if (lo) begin
          pend_data_d = out_data;
          pending_d   = 1'b1;
        end
      end
      StLatch: begin
        bcd_d        = shift_q[19:8];
        disp_valid_d = 1'b1;
        if (lo) begin
          shift_d   = {12'h000, out_data};
          iter_d    = 3'd0;
          pending_d = 1'b0;
          state_d   = StConv;
        end else if (pending_q) begin
          shift_d   = {12'h000, pend_data_q};
          iter_d    = 3'd0;
          pending_d = 1'b0;
          state_d   = StConv;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    refresh_d = refresh_q + 16'd1;
    sel_d     = sel_q;
    if (refresh_q == 16'(REFRESH_DIV - 1)) begin
      refresh_d = 16'd0;
      sel_d     = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      shift_q      <= 20'h00000;
      iter_q       <= 3'd0;
      pending_q    <= 1'b0;
      pend_data_q  <= 8'h00;
      bcd_q        <= 12'h000;
      disp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      refresh_q    <= 16'd0;
      sel_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      iter_q       <= iter_d;
      pending_q    <= pending_d;
      pend_data_q  <= pend_data_d;
      bcd_q        <= bcd_d;
      disp_valid_q <= disp_valid_d;
      busy_q       <= (state_d != StIdle);
      refresh_q    <= refresh_d;
      sel_q        <= sel_d;
    end
  end

  // Leading-zero blanking; the ones digit always shows.
  always_comb begin
    digit = bcd_q[3:0];
    blank = 1'b0;
    case (sel_q)
      2'd1: begin
        digit = bcd_q[7:4];
        blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
      end
      2'd2: begin
        digit = bcd_q[11:8];
        blank = (bcd_q[11:8] == 4'd0);
      end
      default: begin
        digit = bcd_q[3:0];
        blank = 1'b0;
      end
    endcase
  end

  assign busy       = busy_q;
  assign disp_valid = disp_valid_q;
  assign bcd        = bcd_q;
  assign an         = 3'b001 << sel_q;
  assign seg        = blank ? 7'h00 : seg_decode(digit);

endmodule

// File: tb/tb_sap1_out_display.sv
// Scoreboard bench for sap1_out_display: a timing-level reference model queues expected latch
// results; a negedge monitor pops them and checks every output each cycle.
module tb_sap1_out_display;

  localparam int RDIV = 4;
  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  typedef struct {
    int          due;
    logic [11:0] bcd;
    logic        valid;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lo = 1'b0;
  logic [7:0]  out_data = 8'h00;
  logic        busy;
  logic        disp_valid;
  logic [11:0] bcd;
  logic [2:0]  an;
  logic [6:0]  seg;

  sap1_out_display #(.REFRESH_DIV(RDIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .out_data   (out_data),
    .lo         (lo),
    .busy       (busy),
    .disp_valid (disp_valid),
    .bcd        (bcd),
    .an         (an),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          cyc = 0;
  int          rst_edge = 0;
  bit          started = 1'b0;
  bit          m_active = 1'b0;
  int          m_end = 0;
  logic [7:0]  m_val = 8'h00;
  bit          m_pend = 1'b0;
  logic [7:0]  m_pend_d = 8'h00;
  bit          m_busy = 1'b0;
  int          m_sel = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [11:0] to_bcd(input logic [7:0] v);
    int x;
    x = int'(v);
    return 12'((x / 100) * 256 + ((x / 10) % 10) * 16 + (x % 10));
  endfunction

  function automatic logic [6:0] exp_seg(input logic [11:0] b, input int sel);
    int h, t, o;
    h = int'(b[11:8]);
    t = int'(b[7:4]);
    o = int'(b[3:0]);
    if (sel == 2) return (h == 0) ? 7'h00 : SEG_TAB[h];
    if (sel == 1) return (h == 0 && t == 0) ? 7'h00 : SEG_TAB[t];
    return SEG_TAB[o];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model, updated with the inputs sampled at the edge just taken.
  task automatic model(input logic l, input logic [7:0] d, input logic r);
    cyc++;
    if (r) begin
      sb.delete();
      sb.push_back('{cyc, 12'h000, 1'b0});
      m_active = 1'b0;
      m_pend   = 1'b0;
      rst_edge = cyc;
    end else if (m_active && cyc == m_end) begin
      sb.push_back('{cyc, to_bcd(m_val), 1'b1});
      if (l) begin
        m_val  = d;
        m_end  = cyc + 9;
        m_pend = 1'b0;
      end else if (m_pend) begin
        m_val  = m_pend_d;
        m_end  = cyc + 9;
        m_pend = 1'b0;
      end else begin
        m_active = 1'b0;
      end
    end else if (m_active) begin
      if (l) begin
        m_pend   = 1'b1;
        m_pend_d = d;
      end
    end else if (l) begin
      m_active = 1'b1;
      m_val    = d;
      m_end    = cyc + 9;
    end
    m_busy  = m_active;
    m_sel   = ((cyc - rst_edge) / RDIV) % 3;
    started = 1'b1;
  endtask

  task automatic step(input logic l, input logic [7:0] d, input logic r);
    lo       = l;
    out_data = d;
    rst      = r;
    @(posedge clk);
    model(l, d, r);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  // Monitor: retire due scoreboard entries, then check all outputs against the expected display.
  initial begin
    exp_t        e;
    logic [11:0] e_bcd;
    logic        e_valid;
    e_bcd   = 12'h000;
    e_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (started) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          chk("latch_bcd", 32'(bcd), 32'(e.bcd));
          chk("latch_valid", 32'(disp_valid), 32'(e.valid));
          e_bcd   = e.bcd;
          e_valid = e.valid;
        end
        chk("busy", 32'(busy), 32'(m_busy));
        chk("disp_valid", 32'(disp_valid), 32'(e_valid));
        chk("bcd", 32'(bcd), 32'(e_bcd));
        chk("an", 32'(an), 32'(3'b001 << m_sel));
        chk("seg", 32'(seg), 32'(exp_seg(e_bcd, m_sel)));
      end
    end
  end

  initial begin
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    idle(20);
    step(1'b1, 8'hF7, 1'b0);
    idle(20);
    step(1'b1, 8'h05, 1'b0);
    idle(20);
    step(1'b1, 8'h0A, 1'b0);
    idle(20);
    // Overlapping loads: 02 is overwritten by 03 while 01 converts.
    step(1'b1, 8'h01, 1'b0);
    idle(2);
    step(1'b1, 8'h02, 1'b0);
    idle(1);
    step(1'b1, 8'h03, 1'b0);
    idle(20);
    step(1'b1, 8'hFF, 1'b0);
    idle(20);
    // Reset in the middle of a conversion.
    step(1'b1, 8'hC8, 1'b0);
    idle(3);
    step(1'b0, 8'h00, 1'b1);
    idle(20);
    // lo held high continuously.
    for (int i = 0; i < 30; i++) step(1'b1, 8'($urandom), 1'b0);
    idle(20);
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 199) == 0));
    end
    idle(20);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
